pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Sequences the iCE40 PLL wrapper (`pll`) at power-up and keeps it supervised:
- pulses the PLL reset;
- waits for `locked` with a timeout and bounded retries;
- qualifies lock as stable before releasing the system reset to the ILI9341 display pipeline.

It runs on the 16 MHz board reference clock, which is alive before the PLL locks. Its `sys_resetn` output gates every PLL-clocked block downstream.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16, cycles `pll_resetb` is held low per attempt (≥1)
- `LOCK_TIMEOUT`, 4096, cycles allowed in WAIT_LOCK before an attempt fails (≥2)
- `STABLE_CYCLES`, 1024, consecutive synchronized-lock cycles required before release (≥1)
- `MAX_RETRIES`, 3, failed attempts tolerated before FAIL (1..15)

Ports:
- `clock_in`  in  1  16 MHz reference clock; the only clock
- `resetn`  in  1  asynchronous, active-low reset
- `locked_in`  in  1  PLL `locked`; asynchronous, double-flop synchronized internally
- `pll_resetb`  out  1  drives PLL RESETB; 0 = PLL held in reset
- `sys_resetn`  out  1  active-low system reset to the PLL-clock domain
- `ready`  out  1  high while in RUN
- `fail`  out  1  high while in FAIL
- `retry_count`  out  4  failed attempts since `resetn`, saturating at 15

## Operation
- Synchronizer: `lock_s` = `locked_in` after two `clock_in` flops. Both flops reset to 0. All decisions use `lock_s`.
- States: PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL. One shared counter `cnt`, width `$clog2` of the largest parameter + 1.
- **PLL_RST**:
  - `pll_resetb`=0, `cnt` increments.
  - At `cnt`==PLL_RST_CYCLES-1: go to WAIT_LOCK, clear `cnt`.
- **WAIT_LOCK**:
  - `pll_resetb`=1, `cnt` increments.
  - `lock_s`=1: go to STABLE, clear `cnt`.
  - Otherwise, at `cnt`==LOCK_TIMEOUT-1 (timeout): increment `retry_count`.
    - If the new value == MAX_RETRIES: go to FAIL.
    - Else: go to PLL_RST, clear `cnt`.
  - Lock and timeout in the same cycle: lock wins, no retry counted.
- **STABLE**:
  - `lock_s`=1: `cnt` increments. At `cnt`==STABLE_CYCLES-1, go to RUN.
  - `lock_s`=0 in any cycle: go back to WAIT_LOCK, clear `cnt`; no retry counted. The timeout window restarts.
- **RUN**:
  - `sys_resetn`=1, `ready`=1.
  - On `lock_s`=0, behaviour depends on `PLL_SUP_RELOCK_EN` (see Configuration).
- **FAIL**:
  - `pll_resetb`=1, `sys_resetn`=0, `fail`=1.
  - Terminal; only `resetn` exits.
- Outputs are registered decodes of the next state. They change on the same edge as the state register.

## Timing
- Reset values:
  - state=PLL_RST, `cnt`=0, `pll_resetb`=0, `sys_resetn`=0, `ready`=0, `fail`=0, `retry_count`=0, sync flops=0.
- `resetn` assertion mid-operation: all of the above take effect immediately (asynchronously), including from RUN or FAIL.
- Deassertion: `pll_resetb` rises exactly PLL_RST_CYCLES rising edges after the first edge with `resetn` high.
- `locked_in` rise to `lock_s`: 2 cycles.
- Release: the first `lock_s`=1 cycle in WAIT_LOCK is followed by `sys_resetn`=1 after exactly 1 + STABLE_CYCLES edges.
- Lock loss in RUN: `sys_resetn` falls 3 edges after `locked_in` falls (2 sync + 1 state).
- `retry_count` updates on the same edge that leaves WAIT_LOCK on timeout.

## Configuration
`PLL_SUP_RELOCK_EN`:
- **Defined**:
  - `lock_s`=0 in RUN: go to PLL_RST, `sys_resetn`=0 next edge, `cnt` cleared.
  - `retry_count` is not incremented and full re-sequencing follows.
- **Undefined**:
  - `lock_s`=0 in RUN: go to FAIL next edge; `sys_resetn`=0, `fail`=1.
  - `retry_count` is unchanged.

## Test plan
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT=16, STABLE_CYCLES=8, MAX_RETRIES=2.

- **Clean lock:** release `resetn`; raise `locked_in` 5 cycles after `pll_resetb` rises -> `sys_resetn` and `ready` rise 2+1+8 edges after `locked_in`; `retry_count`=0.
- **Timeout/retry/fail:** hold `locked_in`=0 -> `pll_resetb` low 4, high 16, low 4, high 16; `retry_count` 1 then 2; `fail`=1, `pll_resetb`=1, `sys_resetn`=0 permanently.
- **Glitch in STABLE:** lock high 5 cycles, low 1, high again -> STABLE restarts; `sys_resetn` rises 11 edges after the second rise; `retry_count`=0.
- **Lock lost in RUN, with `PLL_SUP_RELOCK_EN`:** drop `locked_in` -> `sys_resetn`=0 3 edges later; `pll_resetb`=0 for 4 cycles; re-lock returns to RUN; `retry_count`=0.
- **Lock lost in RUN, without `PLL_SUP_RELOCK_EN`:** drop `locked_in` -> `fail`=1 and `sys_resetn`=0 3 edges later; `pll_resetb` stays 1.
- **Async reset mid-STABLE, and lock/timeout same cycle:**
  - Assert `resetn` mid-STABLE -> all outputs reach reset values before the next edge.
  - Align `lock_s` rise with `cnt`=15 -> STABLE entered, `retry_count` unchanged.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// Power-up sequencer and lock supervisor for the iCE40 PLL, running on the 16 MHz reference clock.
// Optional feature: define PLL_SUP_RELOCK_EN to re-sequence the PLL on lock loss in RUN instead of failing.
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 4096,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 3
) (
    input  logic       clock_in,
    input  logic       resetn,
    input  logic       locked_in,
    output logic       pll_resetb,
    output logic       sys_resetn,
    output logic       ready,
    output logic       fail,
    output logic [3:0] retry_count
);

    localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_ALL = (MAX_AB > STABLE_CYCLES) ? MAX_AB : STABLE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_ALL) + 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [3:0]       RETRY_LIMIT  = 4'(MAX_RETRIES);

    localparam logic [2:0] ST_PLL_RST   = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAIL      = 3'd4;

    logic [2:0]       state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic [3:0]       retry_next, retry_inc;
    logic             sync_q1, lock_s;

    // locked_in comes from the PLL with no relation to clock_in.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            sync_q1 <= 1'b0;
            lock_s  <= 1'b0;
        end else begin
            sync_q1 <= locked_in;
            lock_s  <= sync_q1;
        end
    end

    assign retry_inc = (retry_count == 4'd15) ? 4'd15 : retry_count + 4'd1;

    // NOTE: every variable gets a default at the top of the block so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        retry_next = retry_count;
        case (state)
            ST_PLL_RST: begin
                if (cnt == RST_LAST) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_WAIT_LOCK: begin
                // Lock takes priority over a timeout landing in the same cycle.
                if (lock_s) begin
                    state_next = ST_STABLE;
                    cnt_next   = '0;
                end else if (cnt == TIMEOUT_LAST) begin
                    retry_next = retry_inc;
                    state_next = (retry_inc == RETRY_LIMIT) ? ST_FAIL : ST_PLL_RST;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_next = ST_WAIT_LOCK;
                    cnt_next   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
`ifdef PLL_SUP_RELOCK_EN
                    state_next = ST_PLL_RST;
`else
                    state_next = ST_FAIL;
`endif
                    cnt_next = '0;
                end
            end
            ST_FAIL: begin
                state_next = ST_FAIL;
            end
            default: begin
                state_next = ST_PLL_RST;
                cnt_next   = '0;
            end
        endcase
    end

    // Outputs decode the next state so they switch on the same edge as the state register.
    always_ff @(posedge clock_in or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_PLL_RST;
            cnt         <= '0;
            retry_count <= 4'd0;
            pll_resetb  <= 1'b0;
            sys_resetn  <= 1'b0;
            ready       <= 1'b0;
            fail        <= 1'b0;
        end else begin
            state       <= state_next;
            cnt         <= cnt_next;
            retry_count <= retry_next;
            pll_resetb  <= (state_next != ST_PLL_RST);
            sys_resetn  <= (state_next == ST_RUN);
            ready       <= (state_next == ST_RUN);
            fail        <= (state_next == ST_FAIL);
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with PLL_RST_CYCLES=4, LOCK_TIMEOUT=16, STABLE_CYCLES=8, MAX_RETRIES=2.
// Inputs change and outputs are sampled on the falling edge; define PLL_SUP_RELOCK_EN to match a relock build.
module tb_pll_lock_supervisor;

    logic       clock_in = 1'b0;
    logic       resetn   = 1'b0;
    logic       locked_in = 1'b0;
    logic       pll_resetb, sys_resetn, ready, fail;
    logic [3:0] retry_count;

    int compared   = 0;
    int mismatched = 0;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES(4),
        .LOCK_TIMEOUT  (16),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2)
    ) dut (
        .clock_in   (clock_in),
        .resetn     (resetn),
        .locked_in  (locked_in),
        .pll_resetb (pll_resetb),
        .sys_resetn (sys_resetn),
        .ready      (ready),
        .fail       (fail),
        .retry_count(retry_count)
    );

    always #5 clock_in = ~clock_in;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "simulation time limit reached");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clock_in);
    endtask

    task automatic check(input string tag, input logic [3:0] observed, input logic [3:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_pll_resetb"}, {3'b0, pll_resetb}, 4'd0);
        check({tag, "_sys_resetn"}, {3'b0, sys_resetn}, 4'd0);
        check({tag, "_ready"},      {3'b0, ready},      4'd0);
        check({tag, "_fail"},       {3'b0, fail},       4'd0);
        check({tag, "_retry"},      retry_count,        4'd0);
    endtask

    // Reset, then release on a falling edge; the next rising edge is the first with resetn high.
    task automatic restart();
        resetn    = 1'b0;
        locked_in = 1'b0;
        tick(2);
        resetn = 1'b1;
    endtask

    initial begin
        // Clean lock
        tick(2);
        check_reset_values("por");
        resetn = 1'b1;
        tick(3);
        check("clean_pll_rst_hold", {3'b0, pll_resetb}, 4'd0);
        tick(1);
        check("clean_pll_rst_rise", {3'b0, pll_resetb}, 4'd1);
        tick(5);
        locked_in = 1'b1;
        tick(10);
        check("clean_sys_before", {3'b0, sys_resetn}, 4'd0);
        tick(1);
        check("clean_sys_release", {3'b0, sys_resetn}, 4'd1);
        check("clean_ready", {3'b0, ready}, 4'd1);
        check("clean_retry", retry_count, 4'd0);

        // Lock lost in RUN
        locked_in = 1'b0;
        tick(2);
        check("loss_sys_hold", {3'b0, sys_resetn}, 4'd1);
        tick(1);
        check("loss_sys_drop", {3'b0, sys_resetn}, 4'd0);
        check("loss_ready_drop", {3'b0, ready}, 4'd0);
`ifdef PLL_SUP_RELOCK_EN
        check("relock_pll_low", {3'b0, pll_resetb}, 4'd0);
        check("relock_fail", {3'b0, fail}, 4'd0);
        tick(3);
        check("relock_pll_hold", {3'b0, pll_resetb}, 4'd0);
        tick(1);
        check("relock_pll_rise", {3'b0, pll_resetb}, 4'd1);
        locked_in = 1'b1;
        tick(10);
        check("relock_sys_before", {3'b0, sys_resetn}, 4'd0);
        tick(1);
        check("relock_sys_release", {3'b0, sys_resetn}, 4'd1);
        check("relock_retry", retry_count, 4'd0);
`else
        check("loss_fail", {3'b0, fail}, 4'd1);
        check("loss_pll_high", {3'b0, pll_resetb}, 4'd1);
        check("loss_retry", retry_count, 4'd0);
        tick(10);
        check("loss_fail_sticky", {3'b0, fail}, 4'd1);
`endif

        // Timeout, retry, fail
        restart();
        tick(4);
        check("to_pll_rise1", {3'b0, pll_resetb}, 4'd1);
        tick(15);
        check("to_pll_high1", {3'b0, pll_resetb}, 4'd1);
        check("to_retry0", retry_count, 4'd0);
        tick(1);
        check("to_pll_low2", {3'b0, pll_resetb}, 4'd0);
        check("to_retry1", retry_count, 4'd1);
        tick(3);
        check("to_pll_hold2", {3'b0, pll_resetb}, 4'd0);
        tick(1);
        check("to_pll_rise2", {3'b0, pll_resetb}, 4'd1);
        tick(15);
        check("to_fail_before", {3'b0, fail}, 4'd0);
        check("to_retry1_hold", retry_count, 4'd1);
        tick(1);
        check("to_fail", {3'b0, fail}, 4'd1);
        check("to_retry2", retry_count, 4'd2);
        check("to_fail_pll", {3'b0, pll_resetb}, 4'd1);
        check("to_fail_sys", {3'b0, sys_resetn}, 4'd0);
        tick(40);
        check("to_fail_sticky", {3'b0, fail}, 4'd1);
        check("to_fail_pll_sticky", {3'b0, pll_resetb}, 4'd1);
        #2 resetn = 1'b0;
        #1 check_reset_values("async_from_fail");

        // Glitch in STABLE
        restart();
        tick(4);
        locked_in = 1'b1;
        tick(5);
        locked_in = 1'b0;
        tick(1);
        locked_in = 1'b1;
        tick(10);
        check("glitch_sys_before", {3'b0, sys_resetn}, 4'd0);
        tick(1);
        check("glitch_sys_release", {3'b0, sys_resetn}, 4'd1);
        check("glitch_retry", retry_count, 4'd0);

        // Async reset mid-STABLE after one timeout
        restart();
        tick(20);
        check("mid_retry1", retry_count, 4'd1);
        tick(4);
        locked_in = 1'b1;
        tick(5);
        check("mid_pll_high", {3'b0, pll_resetb}, 4'd1);
        check("mid_sys_low", {3'b0, sys_resetn}, 4'd0);
        #2 resetn = 1'b0;
        #1 check_reset_values("async_mid_stable");

        // Lock and timeout in the same cycle: lock_s first seen with cnt at its last value
        restart();
        tick(17);
        locked_in = 1'b1;
        tick(3);
        check("tie_pll_high", {3'b0, pll_resetb}, 4'd1);
        check("tie_retry", retry_count, 4'd0);
        tick(7);
        check("tie_sys_before", {3'b0, sys_resetn}, 4'd0);
        tick(1);
        check("tie_sys_release", {3'b0, sys_resetn}, 4'd1);
        check("tie_retry_final", retry_count, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
